// File: rtl/mac_stream.sv
// Pipelined multiply-accumulate: one LEN-term dot product per result.
// Stage 1 registers the full-width product, stage 2 accumulates with overflow/saturation.
module mac_stream #(
  parameter int DATA_W = 4,
  parameter int LEN    = 10,
  parameter int ACC_W  = 12,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          a,
  input  logic [DATA_W-1:0]          b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out,
  output logic                       overflow,
  output logic [$clog2(LEN+1)-1:0]   count
);

  localparam int CW   = $clog2(LEN+1);
  localparam int PW   = 2*DATA_W;
  localparam bit SGN  = (SIGNED != 0);
  localparam bit SATB = (SAT != 0);

  typedef enum logic [1:0] {ACCUM, DRAIN, RESULT} state_e;

  state_e            state, state_nx;
  logic              drain_cnt;
  logic              accept, last_in;
  logic [PW-1:0]     a_ext, b_ext, prod;
  logic              s1_vld, s1_last;
  logic [PW-1:0]     s1_prod;
  logic [ACC_W-1:0]  acc, acc_nx;
  logic              sticky;
  logic [ACC_W:0]    sum;
  logic              step_ovf;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == RESULT);
  assign accept    = in_valid && in_ready;
  assign last_in   = (count == CW'(LEN-1));

  // Extending both operands to 2*DATA_W makes a plain modular multiply exact for either signedness.
  assign a_ext = {{DATA_W{SGN & a[DATA_W-1]}}, a};
  assign b_ext = {{DATA_W{SGN & b[DATA_W-1]}}, b};
  assign prod  = a_ext * b_ext;

  // One guard bit holds the exact sum; its top two bits give the signed V flag.
  assign sum = {SGN & acc[ACC_W-1], acc}
             + {{(ACC_W+1-PW){SGN & s1_prod[PW-1]}}, s1_prod};
  assign step_ovf = SGN ? (sum[ACC_W] != sum[ACC_W-1]) : sum[ACC_W];

  always_comb begin
    acc_nx = sum[ACC_W-1:0];
    if (SATB && step_ovf) begin
      if (!SGN)           acc_nx = {ACC_W{1'b1}};
      else if (sum[ACC_W]) acc_nx = {1'b1, {(ACC_W-1){1'b0}}};
      else                acc_nx = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:   if (accept && last_in) state_nx = DRAIN;
      DRAIN:   if (drain_cnt)         state_nx = RESULT;
      RESULT:  if (out_ready)         state_nx = ACCUM;
      default:                        state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      drain_cnt <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
      acc      <= '0;
      sticky   <= 1'b0;
      count    <= '0;
      out      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
      acc      <= '0;
      sticky   <= 1'b0;
      count    <= '0;
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      s1_vld  <= accept;
      s1_last <= accept && last_in;
      if (accept) s1_prod <= prod;

      // count stays at LEN through DRAIN/RESULT and restarts at the handoff
      if (accept)                          count <= count + 1'b1;
      else if (out_valid && out_ready)     count <= '0;

      if (s1_vld) begin
        if (s1_last) begin
          out      <= acc_nx;
          overflow <= sticky | step_ovf;
          acc      <= '0;
          sticky   <= 1'b0;
        end else begin
          acc    <= acc_nx;
          sticky <= sticky | step_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_stream.sv
// Drives five mac_stream configurations with one shared stream and checks each
// against an integer-arithmetic dot-product model.
module tb_mac_stream;

  localparam int NCFG = 5;
  localparam int LEN  = 10;
  localparam int AWS [NCFG] = '{12, 8, 8, 8, 8};
  localparam int SGS [NCFG] = '{0, 0, 0, 1, 1};
  localparam int STS [NCFG] = '{0, 0, 1, 1, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  a = '0;
  logic [3:0]  b = '0;
  logic        rdy  [NCFG];
  logic        ovld [NCFG];
  logic        ovf  [NCFG];
  logic [3:0]  cnt  [NCFG];
  logic [11:0] ow   [NCFG];

  int n_chk = 0;
  int n_pass = 0;
  logic [3:0] qa[$];
  logic [3:0] qb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    logic [AWS[g]-1:0] o;
    mac_stream #(.DATA_W(4), .LEN(LEN), .ACC_W(AWS[g]), .SIGNED(SGS[g]), .SAT(STS[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[g]),
      .a(a), .b(b), .out_valid(ovld[g]), .out_ready(out_ready), .out(o),
      .overflow(ovf[g]), .count(cnt[g])
    );
    assign ow[g] = 12'(o);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int sval(input logic [3:0] v, input int sg);
    return (sg != 0 && v[3]) ? int'(v) - 16 : int'(v);
  endfunction

  // Exact dot product of the queued pairs with range checks per step.
  function automatic logic [31:0] ref_acc(input int c, output bit ov);
    longint acc, m, lo, hi;
    acc = 0; ov = 1'b0;
    m = longint'(1) << AWS[c];
    if (SGS[c] != 0) begin lo = -(m/2); hi = m/2 - 1; end
    else begin lo = 0; hi = m - 1; end
    foreach (qa[i]) begin
      acc += longint'(sval(qa[i], SGS[c])) * longint'(sval(qb[i], SGS[c]));
      if (acc > hi || acc < lo) begin
        ov = 1'b1;
        if (STS[c] != 0) acc = (acc > hi) ? hi : lo;
        else begin
          acc = acc % m;
          if (acc < 0) acc += m;
          if (SGS[c] != 0 && acc > hi) acc -= m;
        end
      end
    end
    return 32'(acc & (m - 1));
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [3:0] va, input logic [3:0] vb, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin
      step();
      chk("gap_count", cnt[0], qa.size());
    end
    a = va; b = vb; in_valid = 1'b1;
    out_ready = 1'($urandom);
    chk("accum_in_ready", rdy[0], 1);
    step();
    qa.push_back(va); qb.push_back(vb);
    chk("count", cnt[0], qa.size());
  endtask

  // Called just after the edge that accepted the last pair.
  task automatic finish(input int hold);
    logic [31:0] e, e0;
    bit ov;
    out_ready = (hold == 0);
    a = 4'($urandom); b = 4'($urandom);
    for (int k = 0; k < 2; k++) begin
      chk("drain_in_ready", rdy[0], 0);
      chk("drain_out_valid", ovld[0], 0);
      step();
    end
    chk("res_out_valid", ovld[0], 1);
    chk("res_in_ready", rdy[0], 0);
    chk("res_count", cnt[0], LEN);
    e0 = ref_acc(0, ov);
    for (int c = 0; c < NCFG; c++) begin
      e = ref_acc(c, ov);
      chk($sformatf("out_cfg%0d", c), ow[c], e);
      chk($sformatf("ovf_cfg%0d", c), ovf[c], ov);
    end
    repeat (hold) begin
      step();
      chk("hold_out_valid", ovld[0], 1);
      chk("hold_in_ready", rdy[0], 0);
      chk("hold_out", ow[0], e0);
      chk("hold_count", cnt[0], LEN);
    end
    out_ready = 1'b1;
    step();
    chk("handoff_out_valid", ovld[0], 0);
    chk("handoff_in_ready", rdy[0], 1);
    chk("handoff_count", cnt[0], 0);
    in_valid = 1'b0;
    qa.delete(); qb.delete();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < NCFG; c++) begin
      chk("rst_in_ready", rdy[c], 1);
      chk("rst_out_valid", ovld[c], 0);
      chk("rst_out", ow[c], 0);
      chk("rst_overflow", ovf[c], 0);
      chk("rst_count", cnt[c], 0);
    end
    qa.delete(); qb.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic rand_vec(input int max_hold);
    for (int i = 0; i < LEN; i++)
      push(4'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
    finish($urandom_range(0, max_hold));
  endtask

  initial begin
    #1;
    pulse_reset();

    for (int i = 1; i <= LEN; i++) push(4'(i), 4'(i), 0);
    finish(0);

    for (int i = 0; i < LEN; i++) push(4'd15, 4'd15, 0);
    finish(5);

    for (int i = 0; i < LEN; i++) push(4'd5, 4'd6, 0);
    finish(0);

    for (int i = 0; i < LEN; i++) push(4'd8, 4'd7, 0);
    finish(0);

    for (int i = 0; i < LEN; i++) push((i % 2 == 0) ? 4'd13 : 4'd3, 4'd5, 0);
    finish(0);

    // clear mid-vector; the pair presented alongside it must be dropped
    for (int i = 0; i < 4; i++) push(4'($urandom), 4'($urandom), 0);
    clear = 1'b1; in_valid = 1'b1; a = 4'd9; b = 4'd9;
    step();
    clear = 1'b0; in_valid = 1'b0;
    qa.delete(); qb.delete();
    chk("clear_count", cnt[0], 0);
    chk("clear_in_ready", rdy[0], 1);
    chk("clear_out_valid", ovld[0], 0);
    chk("clear_out", ow[0], 0);
    chk("clear_overflow", ovf[1], 0);
    for (int i = 0; i < LEN; i++) push(4'd2, 4'd3, 0);
    finish(0);

    for (int i = 0; i < 5; i++) push(4'($urandom), 4'($urandom), 0);
    pulse_reset();
    rand_vec(0);

    for (int i = 0; i < LEN; i++) push(4'($urandom), 4'($urandom), 0);
    out_ready = 1'b0; in_valid = 1'b0;
    step(); step();
    chk("pre_rst_out_valid", ovld[0], 1);
    pulse_reset();
    rand_vec(2);

    for (int v = 0; v < 8; v++) rand_vec(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
